systolic_array_param: RTL and testbench
=======================================

SYSTOLIC_ARRAY_PARAM -- requirements
Module: systolic_array_param

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of PE rows (2..16).
REQ-002 SHALL have parameter COLS, default 4, number of PE columns (2..16).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, signed operand width.
REQ-004 SHALL have parameter ACC_WIDTH, default 32, signed accumulator width (>= 2*DATA_WIDTH).
REQ-005 SHALL have port array_clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port array_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle job start, sampled only in IDLE.
REQ-008 SHALL have port k_len  input  16  inner-dimension length, sampled with start.
REQ-009 SHALL have port in_valid  input  1  operand beat valid.
REQ-010 SHALL have port in_ready  output  1  operand beat accepted when in_valid&in_ready.
REQ-011 SHALL have port a_vec  input  ROWS*DATA_WIDTH  left operands, row r at bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port b_vec  input  COLS*DATA_WIDTH  top operands, column c packed the same way.
REQ-013 SHALL have port out_valid  output  1  result row valid.
REQ-014 SHALL have port out_ready  input  1  result row consumed when out_valid&out_ready.
REQ-015 SHALL have port out_row  output  COLS*ACC_WIDTH  accumulators of row out_idx, column c at [c*ACC_WIDTH +: ACC_WIDTH].
REQ-016 SHALL have port out_idx  output  $clog2(ROWS)  index of row on out_row.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse after last row handshake.

Function
REQ-019 SHALL implement output-stationary C[r][c] = sum over k of A[r][k]*B[k][c], one beat = column k of A and row k of B.
REQ-020 SHALL use FSM states IDLE, FEED, FLUSH, DRAIN; IDLE->FEED on start with k_len>0; IDLE->DRAIN on start with k_len==0 (all-zero result).
REQ-021 SHALL clear all accumulators and skew/pipeline registers on the start cycle.
REQ-022 SHALL assert in_ready only in FEED; FEED->FLUSH on the k_len-th accepted beat.
REQ-023 SHALL advance array (skew shift, operand pass right/down, MAC) only on advance = (FEED & in_valid) | FLUSH; all array state holds otherwise (bubbles tolerated).
REQ-024 SHALL delay row r operand by r advances and column c operand by c advances via skew registers; zeros injected during FLUSH.
REQ-025 SHALL register operand pass-through in each PE (one advance per hop) and accumulate signed product sign-extended to ACC_WIDTH.
REQ-026 SHALL stay in FLUSH exactly ROWS+COLS-1 cycles, then enter DRAIN with out_idx=0.
REQ-027 SHALL in DRAIN hold out_valid high and out_row/out_idx stable until handshake; increment out_idx per handshake; after row ROWS-1 handshake go IDLE and pulse done next cycle.
REQ-028 SHALL ignore start outside IDLE; SHALL ignore in_valid outside FEED.
REQ-029 SHALL by default wrap accumulator arithmetic modulo 2^ACC_WIDTH.

Reset
REQ-030 SHALL on array_rst, at any time including mid-job, force IDLE, zero accumulators and pipeline, and drive in_ready=0, out_valid=0, out_row=0, out_idx=0, busy=0, done=0.
REQ-031 SHALL accept start on the first rising edge after array_rst deasserts.

Configuration
REQ-032 SHALL, with macro SYSTOLIC_ARRAY_SAT_EN defined, saturate each accumulate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; without it, wrap per REQ-029.

Verification
REQ-033 SHALL cover identity: ROWS=COLS=4, k_len=4, A=I, B[k][c]=k*4+c, in_valid always 1 -> rows 0..3 equal B rows, done one cycle after 4th handshake.
REQ-034 SHALL cover bubbles: same job with in_valid toggling 1,0,1,0 -> identical results to REQ-033.
REQ-035 SHALL cover backpressure: out_ready low 5 cycles at row 2 -> out_row/out_idx=2 stable, no row skipped or repeated.
REQ-036 SHALL cover k_len=0 -> no in_ready, 4 all-zero rows, done pulse.
REQ-037 SHALL cover overflow: ACC_WIDTH=16, A=B=127 all, k_len=3 -> 48387 wraps to -17149 without macro, 32767 with SYSTOLIC_ARRAY_SAT_EN.
REQ-038 SHALL cover reset mid-FLUSH then new job with k_len=2, A=B=1 -> all outputs reset values, second job yields 2 in every element.

Source files
------------

// File: rtl/systolic_array_param.sv
// Purpose  : ROWSxCOLS output-stationary systolic array of signed MACs computing C = A*B.
// Latency  : k_len operand beats, then ROWS+COLS-1 flush cycles, then one result row per out handshake.
// Backpress: bubbles on in_valid freeze the whole array; out_ready low holds the current result row.
//
// Ports:
//   array_clk / array_rst   sole clock (rising edge) and asynchronous active-high reset
//   start, k_len            job start and inner-dimension length, sampled only in IDLE
//   in_valid / in_ready     operand beat handshake; a_vec = column k of A, b_vec = row k of B
//   out_valid / out_ready   result row handshake; out_row = C[out_idx][*], column c at [c*ACC_WIDTH +: ACC_WIDTH]
//   busy, done              busy outside IDLE; done pulses the cycle after the last row handshake
// Build option: define SYSTOLIC_ARRAY_SAT_EN to saturate accumulators instead of wrapping.
module systolic_array_param #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                       array_clk,
   input  logic                       array_rst,
   input  logic                       start,
   input  logic [15:0]                k_len,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ROWS*DATA_WIDTH-1:0] a_vec,
   input  logic [COLS*DATA_WIDTH-1:0] b_vec,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [COLS*ACC_WIDTH-1:0]  out_row,
   output logic [$clog2(ROWS)-1:0]    out_idx,
   output logic                       busy,
   output logic                       done
);

   localparam int DW    = DATA_WIDTH;
   localparam int AW    = ACC_WIDTH;
   localparam int IDX_W = $clog2(ROWS);
   localparam int FL_W  = $clog2(ROWS + COLS);

   typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [15:0]      r_k_cnt;
   logic [15:0]      r_k_last;
   logic [FL_W-1:0]  r_flush_cnt;
   logic [IDX_W-1:0] r_out_idx;
   logic             r_done;

   logic w_clear;
   logic w_adv;
   logic w_feed;
   logic w_out_hs;
   logic w_last_row;

   // Array interconnect: skew outputs feed column 0 / row 0, pass registers feed the rest.
   logic [DW-1:0] w_a_skew [ROWS];
   logic [DW-1:0] w_b_skew [COLS];
   logic [DW-1:0] w_a_pass [ROWS][COLS-1];
   logic [DW-1:0] w_b_pass [ROWS-1][COLS];
   logic [AW-1:0] w_acc    [ROWS][COLS];

   assign w_feed     = (r_state == FEED);
   assign w_clear    = (r_state == IDLE) && start;
   assign w_adv      = (w_feed && in_valid) || (r_state == FLUSH);
   assign w_out_hs   = (r_state == DRAIN) && out_ready;
   assign w_last_row = (r_out_idx == IDX_W'(ROWS - 1));

   //---------------------------------------------------------------- FSM
   always_ff @(posedge array_clk or posedge array_rst) begin
      if (array_rst) r_state <= IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = (k_len == 16'd0) ? DRAIN : FEED;
         end
         FEED: begin
            in_ready = 1'b1;
            if (in_valid && (r_k_cnt == r_k_last)) w_state_nxt = FLUSH;
         end
         FLUSH: begin
            // The last beat needs ROWS+COLS-1 advances to reach the far corner PE.
            if (r_flush_cnt == FL_W'(ROWS + COLS - 2)) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && w_last_row) w_state_nxt = IDLE;
         end
         default: begin
            busy        = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------- counters
   always_ff @(posedge array_clk or posedge array_rst) begin
      if (array_rst) begin
         r_k_cnt     <= '0;
         r_k_last    <= '0;
         r_flush_cnt <= '0;
         r_out_idx   <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_out_hs && w_last_row;
         if (w_clear) begin
            r_k_cnt     <= '0;
            r_k_last    <= k_len - 16'd1;
            r_flush_cnt <= '0;
            r_out_idx   <= '0;
         end else begin
            if (w_feed && in_valid)   r_k_cnt     <= r_k_cnt + 16'd1;
            if (r_state == FLUSH)     r_flush_cnt <= r_flush_cnt + FL_W'(1);
            if (w_out_hs)             r_out_idx   <= w_last_row ? '0 : r_out_idx + IDX_W'(1);
         end
      end
   end

   assign out_idx = r_out_idx;
   assign done    = r_done;

   //---------------------------------------------------------------- input skew
   // Row r is delayed by r advances (column c likewise) so operands of the same
   // beat meet in PE(r,c) on the same advance. Zeros enter once FEED ends.
   for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
      logic [DW-1:0] w_edge;
      assign w_edge = w_feed ? a_vec[r*DW +: DW] : '0;
      if (r == 0) begin : g_direct
         assign w_a_skew[r] = w_edge;
      end else begin : g_dly
         logic [DW-1:0] r_sk [r];
         always_ff @(posedge array_clk or posedge array_rst) begin
            if (array_rst) begin
               for (int i = 0; i < r; i++) r_sk[i] <= '0;
            end else if (w_clear) begin
               for (int i = 0; i < r; i++) r_sk[i] <= '0;
            end else if (w_adv) begin
               r_sk[0] <= w_edge;
               for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
            end
         end
         assign w_a_skew[r] = r_sk[r-1];
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_b_skew
      logic [DW-1:0] w_edge;
      assign w_edge = w_feed ? b_vec[c*DW +: DW] : '0;
      if (c == 0) begin : g_direct
         assign w_b_skew[c] = w_edge;
      end else begin : g_dly
         logic [DW-1:0] r_sk [c];
         always_ff @(posedge array_clk or posedge array_rst) begin
            if (array_rst) begin
               for (int i = 0; i < c; i++) r_sk[i] <= '0;
            end else if (w_clear) begin
               for (int i = 0; i < c; i++) r_sk[i] <= '0;
            end else if (w_adv) begin
               r_sk[0] <= w_edge;
               for (int i = 1; i < c; i++) r_sk[i] <= r_sk[i-1];
            end
         end
         assign w_b_skew[c] = r_sk[c-1];
      end
   end

   //---------------------------------------------------------------- PE grid
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic signed [DW-1:0]   w_a;
         logic signed [DW-1:0]   w_b;
         logic signed [2*DW-1:0] w_prod;
         logic signed [AW-1:0]   w_ext;
         logic signed [AW-1:0]   w_acc_nxt;
         logic signed [AW-1:0]   r_acc;

         if (c == 0) begin : g_a_in
            assign w_a = w_a_skew[r];
         end else begin : g_a_in
            assign w_a = w_a_pass[r][c-1];
         end
         if (r == 0) begin : g_b_in
            assign w_b = w_b_skew[c];
         end else begin : g_b_in
            assign w_b = w_b_pass[r-1][c];
         end

         // Edge PEs have no neighbour to feed, so they carry no pass register.
         if (c < COLS - 1) begin : g_a_pass
            logic [DW-1:0] r_a;
            always_ff @(posedge array_clk or posedge array_rst) begin
               if (array_rst)    r_a <= '0;
               else if (w_clear) r_a <= '0;
               else if (w_adv)   r_a <= w_a;
            end
            assign w_a_pass[r][c] = r_a;
         end
         if (r < ROWS - 1) begin : g_b_pass
            logic [DW-1:0] r_b;
            always_ff @(posedge array_clk or posedge array_rst) begin
               if (array_rst)    r_b <= '0;
               else if (w_clear) r_b <= '0;
               else if (w_adv)   r_b <= w_b;
            end
            assign w_b_pass[r][c] = r_b;
         end

         // Signed casts sign-extend the operands before the multiply.
         assign w_prod = (2*DW)'(w_a) * (2*DW)'(w_b);
         assign w_ext  = AW'(w_prod);

`ifdef SYSTOLIC_ARRAY_SAT_EN
         logic [AW:0] w_sum;
         assign w_sum = {r_acc[AW-1], r_acc} + {w_ext[AW-1], w_ext};
         always_comb begin
            w_acc_nxt = w_sum[AW-1:0];
            // Differing top two bits of the widened sum mean overflow; clamp by sign.
            if (w_sum[AW] != w_sum[AW-1])
               w_acc_nxt = w_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
         end
`else
         assign w_acc_nxt = r_acc + w_ext;
`endif

         always_ff @(posedge array_clk or posedge array_rst) begin
            if (array_rst)    r_acc <= '0;
            else if (w_clear) r_acc <= '0;
            else if (w_adv)   r_acc <= w_acc_nxt;
         end
         assign w_acc[r][c] = r_acc;
      end
   end

   //---------------------------------------------------------------- result mux
   always_comb begin
      out_row = '0;
      if (r_state == DRAIN) begin
         for (int r = 0; r < ROWS; r++) begin
            if (r_out_idx == IDX_W'(r)) begin
               for (int c = 0; c < COLS; c++) out_row[c*AW +: AW] = w_acc[r][c];
            end
         end
      end
   end

endmodule

// File: tb/tb_systolic_array_param.sv
module tb_systolic_array_param;

   localparam int R  = 4;
   localparam int C  = 4;
   localparam int DW = 8;
   localparam int AW = 16;

   logic            array_clk = 1'b0;
   logic            array_rst;
   logic            start;
   logic [15:0]     k_len;
   logic            in_valid;
   logic            in_ready;
   logic [R*DW-1:0] a_vec;
   logic [C*DW-1:0] b_vec;
   logic            out_valid;
   logic            out_ready;
   logic [C*AW-1:0] out_row;
   logic [1:0]      out_idx;
   logic            busy;
   logic            done;

   always #5 array_clk = ~array_clk;

   systolic_array_param #(
      .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
   ) u_dut (
      .array_clk(array_clk), .array_rst(array_rst), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_idx(out_idx), .busy(busy), .done(done)
   );

   typedef struct {
      logic [1:0]      idx;
      logic [C*AW-1:0] row;
   } exp_t;

   exp_t sb[$];
   int   ga [R][16];
   int   gb [16][C];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference accumulate step at 16-bit accumulator width.
   function automatic int mac(input int acc, input int p);
      int s;
      s = acc + p;
`ifdef SYSTOLIC_ARRAY_SAT_EN
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`else
      s = s & 32'hFFFF;
      if (s >= 32768) s = s - 65536;
`endif
      return s;
   endfunction

   task automatic push_model(input int k);
      for (int r = 0; r < R; r++) begin
         exp_t e;
         e.idx = 2'(r);
         e.row = '0;
         for (int c = 0; c < C; c++) begin
            int acc = 0;
            for (int kk = 0; kk < k; kk++) acc = mac(acc, ga[r][kk] * gb[kk][c]);
            e.row[c*AW +: AW] = 16'(acc);
         end
         sb.push_back(e);
      end
   endtask

   task automatic set_identity();
      for (int r = 0; r < R; r++)
         for (int k = 0; k < 16; k++) ga[r][k] = (r == k) ? 1 : 0;
      for (int k = 0; k < 16; k++)
         for (int c = 0; c < C; c++) gb[k][c] = k * 4 + c;
   endtask

   task automatic set_const(input int v);
      for (int r = 0; r < R; r++)
         for (int k = 0; k < 16; k++) ga[r][k] = v;
      for (int k = 0; k < 16; k++)
         for (int c = 0; c < C; c++) gb[k][c] = v;
   endtask

   task automatic start_job(input int k);
      start = 1'b1;
      k_len = 16'(k);
      @(posedge array_clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input int k, input bit bubbles);
      int  i   = 0;
      int  cyc = 0;
      bit  v;
      bit  acc;
      while (i < k && cyc < 200) begin
         v = bubbles ? (cyc % 2 == 0) : 1'b1;
         in_valid = v;
         if (v) begin
            for (int r = 0; r < R; r++) a_vec[r*DW +: DW] = 8'(ga[r][i]);
            for (int c = 0; c < C; c++) b_vec[c*DW +: DW] = 8'(gb[i][c]);
         end else begin
            a_vec = $urandom;
            b_vec = $urandom;
         end
         acc = v && in_ready;
         @(posedge array_clk); #1;
         if (acc) i++;
         cyc++;
      end
      in_valid = 1'b0;
      check("feed_beats", 64'(i), 64'(k));
   endtask

   task automatic drain(input int stall_row);
      int   n = 0;
      exp_t e;
      while (!out_valid && n < 100) begin
         @(posedge array_clk); #1;
         n++;
      end
      check("drain_valid", out_valid, 1);
      check("drain_in_rdy", in_ready, 0);
      check("sb_depth", 64'(sb.size()), 64'(R));
      for (int r = 0; r < R; r++) begin
         e.idx = 2'(r);
         e.row = '0;
         if (sb.size() != 0) e = sb.pop_front();
         if (r == stall_row) begin
            out_ready = 1'b0;
            repeat (5) begin
               @(posedge array_clk); #1;
               check("stall_valid", out_valid, 1);
               check("stall_idx", out_idx, e.idx);
               check("stall_row", out_row, e.row);
            end
         end
         out_ready = 1'b1;
         check($sformatf("row%0d_idx", r), out_idx, e.idx);
         check($sformatf("row%0d_dat", r), out_row, e.row);
         check($sformatf("row%0d_done", r), done, 0);
         @(posedge array_clk); #1;
      end
      out_ready = 1'b0;
      check("done_pulse", done, 1);
      check("idle_busy", busy, 0);
      check("idle_valid", out_valid, 0);
      @(posedge array_clk); #1;
      check("done_low", done, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_row"}, out_row, 0);
      check({tag, "_out_idx"}, out_idx, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      array_rst = 1'b1;
      start     = 1'b0;
      k_len     = '0;
      in_valid  = 1'b0;
      a_vec     = '0;
      b_vec     = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge array_clk);
      #1;
      check_reset_outputs("rst");
      array_rst = 1'b0;
      @(posedge array_clk); #1;

      // Identity A, streaming beats.
      set_identity();
      push_model(4);
      start_job(4);
      check("feed_busy", busy, 1);
      feed(4, 1'b0);
      drain(-1);

      // Same job with in_valid alternating 1,0.
      push_model(4);
      start_job(4);
      feed(4, 1'b1);
      drain(-1);

      // Backpressure on row 2.
      push_model(4);
      start_job(4);
      feed(4, 1'b0);
      drain(2);

      // Empty inner dimension.
      push_model(0);
      start_job(0);
      check("k0_in_ready", in_ready, 0);
      check("k0_busy", busy, 1);
      drain(-1);

      // Accumulator overflow.
      set_const(127);
      push_model(3);
      start_job(3);
      feed(3, 1'b0);
      drain(-1);

      // Reset in the middle of FLUSH, then a fresh job.
      set_identity();
      start_job(4);
      feed(4, 1'b0);
      check("flush_busy", busy, 1);
      check("flush_in_ready", in_ready, 0);
      @(posedge array_clk); #1;
      array_rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(posedge array_clk); #1;
      array_rst = 1'b0;
      set_const(1);
      push_model(2);
      start_job(2);
      check("post_rst_busy", busy, 1);
      feed(2, 1'b0);
      drain(-1);

      check("sb_empty", 64'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
